// File: rtl/sha3_fsm1_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_fsm1_loader
//  Description : SHA3 input controller. Reads header and message words,
//                appends pad10*1 (0x06 ... 0x80) and sequences permutations.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha3_fsm1_loader #(
    parameter int w          = 64,
    parameter int RATE_WORDS = 17,
    parameter int LEN_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_ready,
    output logic         src_read,
    input  logic [w-1:0] din,
    output logic [w-1:0] dout,
    output logic         ein,
    output logic         perm_start,
    input  logic         perm_done,
    output logic         last_block,
    output logic         output_write,
    input  logic         output_write_clr,
    input  logic         output_busy_clr
);
    localparam int               CNT_W       = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(RATE_WORDS - 1);
    localparam logic [7:0]       C_PAD_FIRST = 8'h06;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_LOAD  = 3'd1,
        S_PAD   = 3'd2,
        S_PERM  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pad_first_q, pad_first_d;
    logic               last_q, last_d;
    logic               obusy_q, obusy_d;

    logic               w_src_avail;
    logic               w_cnt_wrap;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [w-1:0]       w_pad_word;
    logic               w_src_read;

    assign w_src_avail = ~src_ready;
    assign w_cnt_wrap  = (cnt_q == C_CNT_LAST);
    assign w_cnt_next  = w_cnt_wrap ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        w_pad_word = '0;
        if (pad_first_q) w_pad_word[7:0] = C_PAD_FIRST;
        if (w_cnt_wrap)  w_pad_word[w-1] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        pad_first_d  = pad_first_q;
        last_d       = last_q;
        obusy_d      = obusy_q;
        w_src_read   = 1'b0;
        ein          = 1'b0;
        dout         = '0;
        perm_start   = 1'b0;
        last_block   = 1'b0;
        output_write = 1'b0;

        if (output_busy_clr)       obusy_d = 1'b0;
        else if (output_write_clr) obusy_d = 1'b1;

        unique case (state_q)
            S_HDR: begin
                if (w_src_avail) begin
                    w_src_read  = 1'b1;
                    rem_d       = din[LEN_W-1:0];
                    cnt_d       = '0;
                    pad_first_d = 1'b1;
                    state_d     = (din[LEN_W-1:0] != '0) ? S_LOAD : S_PAD;
                end
            end
            S_LOAD: begin
                if (w_src_avail) begin
                    w_src_read = 1'b1;
                    ein        = 1'b1;
                    dout       = din;
                    rem_d      = rem_q - LEN_W'(1);
                    cnt_d      = w_cnt_next;
                    // A block filled by message words always needs a following pad block.
                    if (w_cnt_wrap) begin
                        perm_start = 1'b1;
                        last_d     = 1'b0;
                        state_d    = S_PERM;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                ein         = 1'b1;
                dout        = w_pad_word;
                pad_first_d = 1'b0;
                cnt_d       = w_cnt_next;
                last_block  = 1'b1;
                if (w_cnt_wrap) begin
                    perm_start = 1'b1;
                    last_d     = 1'b1;
                    state_d    = S_PERM;
                end
            end
            S_PERM: begin
                last_block = last_q;
                if (perm_done) begin
                    if (last_q)              state_d = S_FLUSH;
                    else if (rem_q != '0)    state_d = S_LOAD;
                    else                     state_d = S_PAD;
                end
            end
            S_FLUSH: begin
                last_block   = last_q;
                output_write = ~obusy_q;
                if (output_write_clr && ~obusy_q) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    // HDR pops combinationally, so hold the pop off while reset is asserted.
    assign src_read = w_src_read & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HDR;
            rem_q       <= '0;
            cnt_q       <= '0;
            pad_first_q <= 1'b0;
            last_q      <= 1'b0;
            obusy_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            pad_first_q <= pad_first_d;
            last_q      <= last_d;
            obusy_q     <= obusy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha3_fsm1_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha3_fsm1_loader
//  Description : Self-checking bench; messages are expanded into expected
//                absorb words and compared cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_fsm1_loader;
    localparam int W  = 64;
    localparam int RW = 17;
    localparam int LW = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         src_ready;
    logic         src_read;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         ein;
    logic         perm_start;
    logic         perm_done;
    logic         last_block;
    logic         output_write;
    logic         output_write_clr;
    logic         output_busy_clr;

    always #5 clk = ~clk;

    sha3_fsm1_loader #(.w(W), .RATE_WORDS(RW), .LEN_W(LW)) dut (
        .clk              (clk),
        .rst              (rst),
        .src_ready        (src_ready),
        .src_read         (src_read),
        .din              (din),
        .dout             (dout),
        .ein              (ein),
        .perm_start       (perm_start),
        .perm_done        (perm_done),
        .last_block       (last_block),
        .output_write     (output_write),
        .output_write_clr (output_write_clr),
        .output_busy_clr  (output_busy_clr)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         msg;
        logic         eb;
        logic         fin;
    } item_t;

    item_t        exp_q[$];
    logic [W-1:0] src_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           hdr_pend, perm_pend, pend_final, exp_flush, flush_done;
    bit           m_obusy, hold_busy, tog;
    int           perm_cd, flush_wait;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        src_ready        = 1'b0;
        din              = {$urandom, $urandom};
        perm_done        = 1'b0;
        output_write_clr = 1'b0;
        output_busy_clr  = 1'b0;
        #1;
        chk("rst_src_read", src_read, 0);
        chk("rst_ein", ein, 0);
        chk("rst_perm_start", perm_start, 0);
        chk("rst_last_block", last_block, 0);
        chk("rst_output_write", output_write, 0);
        chk("rst_dout", dout, 0);
        repeat (2) @(negedge clk);
        src_ready = 1'b1;
        rst       = 1'b1;
        src_q.delete();
        exp_q.delete();
        hdr_pend  = 0;
        perm_pend = 0;
        exp_flush = 0;
        m_obusy   = 0;
    endtask

    // mode: 0 = source always ready, 1 = ready every other cycle, 2 = random
    task automatic run_msg(input int len, input int mode, input int abort_at);
        int           blocks, total, cyc, eins;
        logic [W-1:0] wd;
        item_t        it;
        bit           avail, e_src, e_ein, e_ow, e_ps;
        logic         e_lb;
        blocks = len / RW + 1;
        total  = RW * blocks;
        wd = {$urandom, $urandom};
        wd[LW-1:0] = LW'(len);
        src_q.push_back(wd);
        hdr_pend = 1;
        for (int i = 0; i < total; i++) begin
            if (i < len) begin
                wd = {$urandom, $urandom};
                src_q.push_back(wd);
                it.data = wd;
                it.msg  = 1'b1;
            end else begin
                it.data = '0;
                if (i == len)       it.data[7:0] = 8'h06;
                if (i == total - 1) it.data[W-1] = 1'b1;
                it.msg = 1'b0;
            end
            it.eb  = (i % RW == RW - 1);
            it.fin = (i / RW == blocks - 1);
            exp_q.push_back(it);
        end
        flush_done = 0;
        cyc  = 0;
        eins = 0;
        while (!flush_done) begin
            if (abort_at > 0 && eins == abort_at) return;
            if (cyc == 3000) begin
                n_cmp++;
                n_bad++;
                $error("FAIL timeout: len %0d observed %0d cycles expected completion", len, cyc);
                return;
            end
            avail = (src_q.size() > 0) &&
                    (mode == 0 || (mode == 1 && tog) || (mode == 2 && $urandom_range(2) != 0));
            tog       = ~tog;
            src_ready = ~avail;
            din       = avail ? src_q[0] : {$urandom, $urandom};
            perm_done = 1'b0;
            if (perm_pend)      perm_done = (perm_cd == 0);
            else if (mode == 2) perm_done = ($urandom_range(7) == 0);
            e_ow = exp_flush && !m_obusy;
            output_write_clr = e_ow && (mode != 2 || $urandom_range(1) == 0);
            if (hold_busy) output_busy_clr = exp_flush && m_obusy && flush_wait == 4;
            else           output_busy_clr = ($urandom_range(3) == 0);
            e_src = avail && !perm_pend && !exp_flush &&
                    (hdr_pend || (exp_q.size() > 0 && exp_q[0].msg));
            e_ein = !perm_pend && !exp_flush && !hdr_pend && exp_q.size() > 0 &&
                    (!exp_q[0].msg || avail);
            e_ps  = e_ein && exp_q[0].eb;
            e_lb  = perm_pend ? pend_final : exp_flush ? 1'b1 : e_ein ? !exp_q[0].msg : 1'b0;
            #1;
            chk("src_read", src_read, e_src);
            chk("ein", ein, e_ein);
            chk("perm_start", perm_start, e_ps);
            chk("last_block", last_block, e_lb);
            chk("output_write", output_write, e_ow);
            if (e_ein) chk("dout", dout, exp_q[0].data);
            @(posedge clk);
            if (e_src) begin
                void'(src_q.pop_front());
                hdr_pend = 0;
            end
            if (exp_flush) begin
                if (output_write_clr) begin
                    exp_flush  = 0;
                    flush_done = 1;
                end else begin
                    flush_wait++;
                end
            end
            if (perm_pend && perm_done) begin
                perm_pend = 0;
                if (pend_final) begin
                    exp_flush  = 1;
                    flush_wait = 0;
                end
            end else if (perm_pend) begin
                perm_cd--;
            end
            if (e_ein) begin
                it = exp_q.pop_front();
                eins++;
                if (it.eb) begin
                    perm_pend  = 1;
                    pend_final = it.fin;
                    perm_cd    = $urandom_range(3);
                end
            end
            if (output_busy_clr)       m_obusy = 0;
            else if (output_write_clr) m_obusy = 1;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; src_ready = 1'b1; din = '0; perm_done = 1'b0;
        output_write_clr = 1'b0; output_busy_clr = 1'b0;
        hold_busy = 0; tog = 0;
        #2;
        do_reset();
        run_msg(0, 0, 0);
        run_msg(16, 0, 0);
        run_msg(17, 0, 0);
        run_msg(5, 1, 0);
        // Second hash must wait for the output FSM to release the first one.
        hold_busy = 1;
        run_msg(3, 0, 0);
        run_msg(20, 0, 0);
        hold_busy = 0;
        run_msg(30, 0, 7);
        do_reset();
        run_msg(1, 0, 0);
        for (int k = 0; k < 6; k++) run_msg($urandom_range(40), 2, 0);
        run_msg(34, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
